// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetch, in-order response FIFO, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [63:0] id_pc_o,
  output logic [63:0] id_pcplus4_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [63:0]      fetch_pc_q;
  logic [63:0]      resp_pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [31:0]      instr_mem [DEPTH];
  logic [63:0]      pc_mem    [DEPTH];

  logic [SUM_W-1:0] in_use_c;
  logic             handshake;
  logic             resp_keep;
  logic             resp_drop;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             fifo_pop;

  // Slots committed = buffered + in flight that will actually be kept.
  assign in_use_c   = SUM_W'(count_q) + SUM_W'(outstanding_q) - SUM_W'(drop_q);
  assign imem_req_o = rst_ni && !redirect_i && (in_use_c < SUM_W'(DEPTH));
  assign handshake  = imem_req_o && imem_gnt_i;
  assign resp_drop  = imem_rvalid_i && (redirect_i || (drop_q != '0));
  assign resp_keep  = imem_rvalid_i && !redirect_i && (drop_q == '0);
  assign imem_addr_o = fetch_pc_q[31:0];

`ifdef FETCH_BYPASS_EN
  assign bypass = rst_ni && resp_keep && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign id_valid_o = rst_ni && !redirect_i && ((count_q != '0) || bypass);
  assign pop        = id_valid_o && id_ready_i;
  assign push       = resp_keep && !(bypass && id_ready_i);
  assign fifo_pop   = pop && !bypass;

  // Head of queue, or the live response when it is being forwarded.
  always_comb begin
    id_instr_o   = '0;
    id_pc_o      = '0;
    id_pcplus4_o = '0;
    if (count_q != '0) begin
      id_instr_o   = instr_mem[rd_ptr_q];
      id_pc_o      = pc_mem[rd_ptr_q];
      id_pcplus4_o = pc_mem[rd_ptr_q] + 64'd1;
    end else if (bypass) begin
      id_instr_o   = imem_rdata_i;
      id_pc_o      = resp_pc_q;
      id_pcplus4_o = resp_pc_q + 64'd1;
    end
  end

  // Control state; a redirect turns everything still in flight into drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else if (redirect_i) begin
      fetch_pc_q    <= redirect_pc_i;
      resp_pc_q     <= redirect_pc_i;
      outstanding_q <= outstanding_q - CNT_W'(imem_rvalid_i);
      drop_q        <= outstanding_q - CNT_W'(imem_rvalid_i);
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      if (handshake) begin
        fetch_pc_q <= fetch_pc_q + 64'd1;
      end
      outstanding_q <= outstanding_q + CNT_W'(handshake) - CNT_W'(imem_rvalid_i);
      if (resp_drop) begin
        drop_q <= drop_q - CNT_W'(1);
      end
      if (resp_keep) begin
        resp_pc_q <= resp_pc_q + 64'd1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    end
  end

  // Payload storage needs no reset; it is only read when count_q is nonzero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against an
// in-order instruction-stream model and a latency-randomized memory.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [63:0] id_pc_o;
  logic [63:0] id_pcplus4_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pcplus4_o(id_pcplus4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          grants = 0;
  int          pops = 0;
  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [63:0] exp_pc = RPC;
  logic [63:0] exp_fetch = RPC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, advance the models.
  task automatic cycle(input bit redir, input logic [63:0] rpc);
    bit rv;
    @(negedge clk_i);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = ($urandom_range(99) < 32'(gnt_pct));
    id_ready_i    = ($urandom_range(99) < 32'(rdy_pct));
    rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    if (redir) begin
      chk("req_in_redirect", 64'(imem_req_o), 64'd0);
      chk("valid_in_redirect", 64'(id_valid_o), 64'd0);
    end
    if (id_valid_o) begin
      chk("id_pc", id_pc_o, exp_pc);
      chk("id_instr", 64'(id_instr_o), 64'(mem_word(exp_pc[31:0])));
      chk("id_pcplus4", id_pcplus4_o, exp_pc + 64'd1);
    end
    if (imem_req_o && imem_gnt_i) begin
      chk("imem_addr", 64'(imem_addr_o), 64'(exp_fetch[31:0]));
      mem_q.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      exp_fetch = exp_fetch + 64'd1;
      grants++;
    end
    if (rv) void'(mem_q.pop_front());
    if (id_valid_o && id_ready_i) begin
      exp_pc = exp_pc + 64'd1;
      pops++;
    end
    if (redir) begin
      exp_pc    = rpc;
      exp_fetch = rpc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    id_ready_i    = 1'b1;
    #1;
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    chk("rst_addr", 64'(imem_addr_o), 64'(RPC[31:0]));
    chk("rst_instr", 64'(id_instr_o), 64'd0);
    chk("rst_pc", id_pc_o, 64'd0);
    chk("rst_pcplus4", id_pcplus4_o, 64'd0);
    mem_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni        = 1'b1;
    imem_rvalid_i = 1'b0;
    exp_pc        = RPC;
    exp_fetch     = RPC;
    cyc           = 0;
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] pc, input int limit, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle(1'b0, '0);
      if (id_valid_o) begin
        seen = 1'b1;
        at   = cyc - 1;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) chk({tag, "_pc"}, id_pc_o, pc);
  endtask

  initial begin
    int g0;
    int p0;
    int rc;
    int at;
    logic [31:0] a0;
    logic [63:0] tgt;

    // Back-to-back streaming from RESET_PC with single-cycle memory.
    do_reset();
    cycle(1'b0, '0);
    chk("first_req", 64'(imem_req_o), 64'd1);
    chk("first_addr", 64'(imem_addr_o), RPC);
    cycle(1'b0, '0);
`ifdef FETCH_BYPASS_EN
    chk("resp_latency", 64'(id_valid_o), 64'd1);
`else
    chk("resp_latency", 64'(id_valid_o), 64'd0);
`endif
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0);
      chk("throughput_valid", 64'(id_valid_o), 64'd1);
    end

    // Decode stalled: at most DEPTH grants, then resume one per cycle.
    do_reset();
    rdy_pct = 0;
    g0 = grants;
    repeat (12) cycle(1'b0, '0);
    chk("stall_grants", 64'(grants - g0), 64'(DEPTH));
    chk("stall_req", 64'(imem_req_o), 64'd0);
    rdy_pct = 100;
    g0 = grants;
    p0 = pops;
    repeat (12) cycle(1'b0, '0);
    chk("resume_pops", 64'(pops - p0), 64'd12);
    chk("resume_grants", 64'(grants - g0), 64'd11);

    // Grant withheld: address and fetch PC hold.
    gnt_pct = 0;
    cycle(1'b0, '0);
    a0 = imem_addr_o;
    g0 = grants;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0);
      chk("hold_addr", 64'(imem_addr_o), 64'(a0));
    end
    chk("hold_grants", 64'(grants - g0), 64'd0);
    gnt_pct = 100;
    repeat (6) cycle(1'b0, '0);

    // Three requests in flight, redirect to 0x40.
    do_reset();
    lat_lo = 4;
    lat_hi = 4;
    repeat (3) cycle(1'b0, '0);
    rc = cyc;
    cycle(1'b1, 64'h40);
    wait_valid("redir3", 64'h40, 20, at);
`ifdef FETCH_BYPASS_EN
    chk("redir_latency", 64'(at - rc), 64'd5);
`else
    chk("redir_latency", 64'(at - rc), 64'd6);
`endif
    repeat (8) cycle(1'b0, '0);

    // Redirect coinciding with a response, then a second redirect to 0x80.
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    repeat (3) cycle(1'b0, '0);
    cycle(1'b1, 64'h40);
    cycle(1'b0, '0);
    cycle(1'b1, 64'h80);
    wait_valid("redir2", 64'h80, 20, at);
    repeat (8) cycle(1'b0, '0);

    // Randomized traffic with redirects (including 64-bit wrap) and a mid-run reset.
    do_reset();
    gnt_pct = 70;
    rdy_pct = 60;
    lat_lo  = 1;
    lat_hi  = 4;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        wait_valid("post_reset", RPC, 40, at);
      end
      if ($urandom_range(99) < 3) begin
        tgt = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
        cycle(1'b1, tgt);
      end else begin
        cycle(1'b0, '0);
      end
    end
    chk("random_progress", 64'(pops - p0 > 300), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
